cpu_trace_monitor: RTL
======================

// Module: cpu_trace_monitor
// PURPOSE
//  Synthesizable commit-trace and halt monitor for the RISC-V CPU top. Each cycle it
//  captures {pc, instr} into a DEPTH-entry trace buffer and detects halt conditions:
//  HALT_PC reached, cycle budget exhausted, or external request. The buffer is drained
//  via a valid/ready port (UART/debug bridge). Replaces the bench-only PC/instr dump and
//  stop logic with hardware usable on the board and in simulation.
// PARAMETERS
//  XLEN        32            width of pc
//  DEPTH       16            trace entries, power of 2, >=2
//  CNT_W       16            width of cycle_cnt and drop_cnt
//  MAX_CYCLES  10000         cycle budget in RUN; 0 disables the limit
//  HALT_PC     32'hFFFFFFFC  commit pc that ends the run
// PORTS
//  clk          in   1            rising-edge clock
//  rstn         in   1            asynchronous active-low reset
//  start        in   1            pulse: IDLE->RUN
//  clear        in   1            pulse: any state->IDLE, flush buffer, zero counters
//  wrap_mode    in   1            1 = overwrite oldest when full; 0 = drop newest
//  halt_req     in   1            external halt request
//  commit_valid in   1            pc/instr describe a retiring instruction
//  pc           in   XLEN         committing pc
//  instr        in   32           committing instruction
//  rd_valid     out  1            buffer head is valid
//  rd_ready     in   1            consumer accepts the head
//  rd_data      out  XLEN+32      {pc, instr} of the oldest entry
//  count        out  $clog2(DEPTH)+1  number of entries held
//  halted       out  1            state == HALTED
//  halt_cause   out  2            0 none, 1 HALT_PC, 2 cycle limit, 3 halt_req
//  cycle_cnt    out  CNT_W        cycles spent in RUN, saturating
//  drop_cnt     out  CNT_W        entries lost to overflow, saturating
// BEHAVIOUR
//  Reset: state=IDLE. rd_valid=0, count=0, halted=0, halt_cause=0, cycle_cnt=0, drop_cnt=0.
//   rd_data is don't-care while rd_valid=0.
//  FSM IDLE -> RUN on start. RUN -> HALTED on the first halt condition.
//   HALTED holds until clear. clear has priority over start and over every other event.
//  RUN, each cycle: cycle_cnt++ (saturating). If commit_valid, push {pc,instr}.
//  Halt check is evaluated in RUN only, with priority HALT_PC > limit > halt_req:
//   commit_valid && pc==HALT_PC -> cause 1. The HALT_PC entry itself is pushed.
//   MAX_CYCLES!=0 && cycle_cnt==MAX_CYCLES-1 this cycle -> cause 2.
//   halt_req -> cause 3. In HALTED, halt_cause is frozen and nothing is pushed.
//  No push in IDLE or HALTED. Draining is permitted in every state.
//  Read latency: a pushed entry is visible on rd_data/rd_valid the cycle after the push.
//   There is no same-cycle bypass, even when the buffer is empty.
//  A pop occurs when rd_valid && rd_ready.
//  Full buffer with a push and no pop:
//   wrap_mode=1: overwrite oldest, advance head, count stays DEPTH, drop_cnt++.
//   wrap_mode=0: discard new entry, drop_cnt++.
//  Full buffer with push and pop in the same cycle: both occur, no drop.
//  Empty buffer with push and pop: the pop is ignored (rd_valid=0) and the push occurs.
//  Pointers are log2(DEPTH) bits and wrap naturally. count = wr - rd, with an extra MSB.
//  Counters saturate at 2^CNT_W-1 and never wrap.
//  clear: next cycle IDLE, count=0, rd_valid=0, counters=0, halt_cause=0.
//  Reset asserted mid-run: immediately returns to the reset values above.
// STRUCTURE
//  Shared package cpu_dbg_pkg: state encodings (IDLE/RUN/HALTED) and HALT_CAUSE_* constants.
//  One sub-module: trace_fifo (DEPTH x (XLEN+32) register array with wr/rd pointers,
//   wrap/drop policy, count). The top holds the FSM, halt detection and counters.
// TESTING
//  1 Reset, start; 5 commits pc=0,4,..,16 with rd_ready=0 -> count=5, rd_data={0,instr0},
//    drop_cnt=0.
//  2 DEPTH=4, wrap_mode=1; 6 commits pc=0..20 -> count=4, head pc=8, drop_cnt=2.
//    Repeat with wrap_mode=0 -> head pc=0, last entry pc=12, drop_cnt=2.
//  3 Commit pc=32'hFFFFFFFC -> that entry is stored, halted=1 next cycle, halt_cause=1.
//    Further commits are not stored; cycle_cnt is frozen.
//  4 MAX_CYCLES=8, commits every cycle, no halt pc -> halted after exactly 8 RUN cycles,
//    halt_cause=2, cycle_cnt=8.
//  5 Full buffer with simultaneous push and pop -> count unchanged, drop_cnt unchanged.
//    Empty buffer with push and rd_ready=1 -> count=1 next cycle.
//  6 rstn low mid-RUN with count=3 -> all outputs at reset values asynchronously.
//    clear while HALTED -> IDLE and count=0.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: run-state encodings and halt-cause codes shared by the trace monitor.
`default_nettype none

package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] HALT_CAUSE_NONE  = 2'd0;
  localparam logic [1:0] HALT_CAUSE_PC    = 2'd1;
  localparam logic [1:0] HALT_CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] HALT_CAUSE_REQ   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH-entry register FIFO with overwrite-oldest or drop-newest overflow policy.
`default_nettype none

module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       wrap_mode,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_en;
  logic             overwrite;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // An empty buffer ignores rd_ready: there is no same-cycle bypass.
  assign pop   = rd_ready && !empty;

  assign wr_en     = push && (!full || pop || wrap_mode);
  assign overwrite = push && full && !pop && wrap_mode;
  assign drop      = push && full && !pop;

  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // Overwriting when full retires the oldest entry, so the head moves too.
      if (pop || overwrite) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !pop && !overwrite) begin
        count <= count + CNT_ONE;
      end else if (pop && !wr_en) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: commit-trace capture with HALT_PC / cycle-budget / external halt detection.
`default_nettype none

module cpu_trace_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter int              CNT_W      = 16,
  parameter int              MAX_CYCLES = 10000,
  parameter logic [XLEN-1:0] HALT_PC    = 32'hFFFFFFFC
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       wrap_mode,
  input  logic                       halt_req,
  input  logic                       commit_valid,
  input  logic [XLEN-1:0]            pc,
  input  logic [31:0]                instr,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [XLEN+31:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halted,
  output logic [1:0]                 halt_cause,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cause_nxt;
  logic       push;
  logic       limit_hit;
  logic       fifo_drop;

  assign limit_hit = (MAX_CYCLES != 0) && (cycle_cnt == LIMIT_M1);
  assign halted    = (state == ST_HALTED);

  always_comb begin
    state_nxt = state;
    cause_nxt = halt_cause;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_IDLE == ST_IDLE ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        push = commit_valid;
        if (commit_valid && (pc == HALT_PC)) begin
          state_nxt = ST_HALTED;
          cause_nxt = HALT_CAUSE_PC;
        end else if (limit_hit) begin
          state_nxt = ST_HALTED;
          cause_nxt = HALT_CAUSE_LIMIT;
        end else if (halt_req) begin
          state_nxt = ST_HALTED;
          cause_nxt = HALT_CAUSE_REQ;
        end
      end
      default: ;
    endcase
    if (clear) begin
      state_nxt = ST_IDLE;
      cause_nxt = HALT_CAUSE_NONE;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      halt_cause <= HALT_CAUSE_NONE;
    end else begin
      state      <= state_nxt;
      halt_cause <= cause_nxt;
    end
  end

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if ((state == ST_RUN) && (cycle_cnt != CNT_MAX)) begin
        cycle_cnt <= cycle_cnt + CNT_ONE;
      end
      if (fifo_drop && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNT_ONE;
      end
    end
  end

  trace_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .push      (push),
    .wrap_mode (wrap_mode),
    .wdata     ({pc, instr}),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .drop      (fifo_drop)
  );

endmodule

`default_nettype wire
